// File: rtl/rib_xbar_rr_pkg.sv
// Shared definitions for the RIB crossbar: FSM state codes and slave-select field width.
package rib_xbar_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } rib_state_e;

  // Width of the slave-index field taken from the top of the address.
  localparam int SEL_W = 4;

endpackage

// File: rtl/rib_xbar_rr_arbiter.sv
// Combinational arbiter: scans requesters from a start index and returns one-hot grant plus index.
// mode_i=1 starts just after ptr_i (round robin), mode_i=0 starts at 0 (fixed priority).
module rib_xbar_rr_arbiter #(
  parameter int NUM_M = 4,
  parameter int IW    = 2
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic             mode_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  always_comb begin
    int   start;
    int   cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    start = 0;
    cand  = 0;
    if (mode_i) start = (int'(ptr_i) + 1) % NUM_M;
    for (int k = 0; k < NUM_M; k++) begin
      cand = (start + k) % NUM_M;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rib_xbar_rr.sv
// RIB interconnect: NUM_M masters share NUM_S slaves through one registered IDLE->ACCESS->RESP path.
// Handshake: a master holds m_req until its one-cycle m_ack; m_hold flags a pending request not completing this cycle.
module rib_xbar_rr
  import rib_xbar_rr_pkg::*;
#(
  parameter int NUM_M    = 4,
  parameter int NUM_S    = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SEL_MSB  = 31,
  parameter int ARB_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M*AW-1:0]     m_addr,
  input  logic [NUM_M*DW-1:0]     m_wdata,
  input  logic [NUM_M*(DW/8)-1:0] m_sel,
  output logic [NUM_M*DW-1:0]     m_rdata,
  output logic [NUM_M-1:0]        m_ack,
  output logic [NUM_M-1:0]        m_err,
  output logic [NUM_M-1:0]        m_hold,
  output logic [NUM_S-1:0]        s_en,
  output logic [NUM_S-1:0]        s_we,
  output logic [AW-1:0]           s_addr,
  output logic [DW-1:0]           s_wdata,
  output logic [DW/8-1:0]         s_sel,
  input  logic [NUM_S*DW-1:0]     s_rdata,
  output logic [1:0]              dbg_state
);

  localparam int SW  = DW / 8;
  localparam int MIW = $clog2(NUM_M);

  rib_state_e       state_q;
  logic [MIW-1:0]   g_q;
  logic [MIW-1:0]   rr_ptr_q;
  logic             we_q;
  logic             derr_q;
  logic [SEL_W-1:0] sidx_q;
  logic [NUM_S-1:0] s_en_q;
  logic [NUM_S-1:0] s_we_q;
  logic [AW-1:0]    s_addr_q;
  logic [DW-1:0]    s_wdata_q;
  logic [SW-1:0]    s_sel_q;
  logic [NUM_M-1:0] m_ack_q;
  logic [NUM_M-1:0] m_err_q;

  logic [NUM_M-1:0] gnt;
  logic [MIW-1:0]   gnt_idx;
  logic [AW-1:0]    g_addr;
  logic [DW-1:0]    g_wdata;
  logic [SW-1:0]    g_sel;
  logic             g_we;
  logic [SEL_W-1:0] g_sidx;
  logic             g_derr;
  logic [DW-1:0]    rd_lane;

  rib_xbar_rr_arbiter #(
    .NUM_M (NUM_M),
    .IW    (MIW)
  ) u_arb (
    .req_i  (m_req),
    .ptr_i  (rr_ptr_q),
    .mode_i (ARB_MODE != 0),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign g_addr  = m_addr[int'(gnt_idx)*AW +: AW];
  assign g_wdata = m_wdata[int'(gnt_idx)*DW +: DW];
  assign g_sel   = m_sel[int'(gnt_idx)*SW +: SW];
  assign g_we    = |(m_we & gnt);
  assign g_sidx  = g_addr[SEL_MSB -: SEL_W];
  assign g_derr  = (int'(g_sidx) >= NUM_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      g_q       <= '0;
      rr_ptr_q  <= MIW'(NUM_M - 1);
      we_q      <= 1'b0;
      derr_q    <= 1'b0;
      sidx_q    <= '0;
      s_en_q    <= '0;
      s_we_q    <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|m_req) begin
            g_q    <= gnt_idx;
            we_q   <= g_we;
            sidx_q <= g_sidx;
            derr_q <= g_derr;
            // The slave bus registers double as the request latches for a decodable access.
            if (!g_derr) begin
              s_en_q    <= NUM_S'(1) << g_sidx;
              s_we_q    <= g_we ? (NUM_S'(1) << g_sidx) : '0;
              s_addr_q  <= g_addr;
              s_wdata_q <= g_wdata;
              s_sel_q   <= g_sel;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          s_en_q    <= '0;
          s_we_q    <= '0;
          s_addr_q  <= '0;
          s_wdata_q <= '0;
          s_sel_q   <= '0;
          m_ack_q   <= NUM_M'(1) << g_q;
          m_err_q   <= derr_q ? (NUM_M'(1) << g_q) : '0;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          m_ack_q <= '0;
          m_err_q <= '0;
          if (ARB_MODE != 0) rr_ptr_q <= g_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Slave read data is synchronous, so it is muxed straight through during RESP.
  always_comb begin
    rd_lane = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (sidx_q == SEL_W'(j)) rd_lane = s_rdata[j*DW +: DW];
    end
    m_rdata = '0;
    m_hold  = m_req;
    for (int i = 0; i < NUM_M; i++) begin
      if (state_q == ST_RESP && g_q == MIW'(i)) begin
        m_hold[i] = 1'b0;
        if (!we_q && !derr_q) m_rdata[i*DW +: DW] = rd_lane;
      end
    end
  end

  assign m_ack     = m_ack_q;
  assign m_err     = m_err_q;
  assign s_en      = s_en_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_sel     = s_sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rib_xbar_rr.sv
// Self-checking bench for rib_xbar_rr: a round-robin instance is fully scoreboarded,
// a fixed-priority instance on the same stimulus is checked during the all-request phase.
module tb_rib_xbar_rr;

  localparam int NUM_M = 4;
  localparam int NUM_S = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_M-1:0]    m_req;
  logic [NUM_M-1:0]    m_we;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_wdata;
  logic [NUM_M*4-1:0]  m_sel;

  logic [NUM_M*DW-1:0] m_rdata, fp_m_rdata;
  logic [NUM_M-1:0]    m_ack, m_err, m_hold, fp_m_ack, fp_m_err, fp_m_hold;
  logic [NUM_S-1:0]    s_en, s_we, fp_s_en, fp_s_we;
  logic [AW-1:0]       s_addr, fp_s_addr;
  logic [DW-1:0]       s_wdata, fp_s_wdata;
  logic [3:0]          s_sel, fp_s_sel;
  logic [NUM_S*DW-1:0] s_rdata, fp_s_rdata;
  logic [1:0]          dbg_state, fp_dbg_state;

  rib_xbar_rr #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SEL_MSB(31), .ARB_MODE(1)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_sel(m_sel), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_hold(m_hold),
    .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_rdata(s_rdata), .dbg_state(dbg_state)
  );

  rib_xbar_rr #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SEL_MSB(31), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_sel(m_sel), .m_rdata(fp_m_rdata), .m_ack(fp_m_ack), .m_err(fp_m_err), .m_hold(fp_m_hold),
    .s_en(fp_s_en), .s_we(fp_s_we), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_sel(fp_s_sel),
    .s_rdata(fp_s_rdata), .dbg_state(fp_dbg_state)
  );

  // Slave model: read data is a function of slave index and address, with one fixed word.
  function automatic logic [31:0] slv_data(int j, logic [31:0] a);
    if (j == 1 && a == 32'h1000_0010) return 32'hDEAD_BEEF;
    return {4'(j), 4'hA, a[23:0]};
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < NUM_S; j++) begin
      s_rdata[j*DW +: DW]    <= (s_en[j] && !s_we[j]) ? slv_data(j, s_addr) : {16'hBAD0, 16'(j)};
      fp_s_rdata[j*DW +: DW] <= (fp_s_en[j] && !fp_s_we[j]) ? slv_data(j, fp_s_addr) : {16'hBAD0, 16'(j)};
    end
  end

  // scoreboard
  logic [34:0] exp_q[$];    // {master, err, rdata}
  logic [72:0] exp_s_q[$];  // {slave, we, addr, wdata, sel}
  int n_vec = 0;
  int n_err = 0;

  // flags and data handed from the driver to the monitor
  logic       rst_chk = 1'b0, lat_chk = 1'b0, gap_chk = 1'b0, fp_chk = 1'b0;
  logic       hold_chk = 1'b0, fin_chk = 1'b0;
  logic [3:0] exp_hold = 4'h0;
  int         req_cyc = 0;
  int         tmo_cnt = 0;

  // monitor-owned state
  int   ack_cnt = 0, last_ack_cyc = 0, gap_n = 0, fp_n = 0, tmo_seen = 0;
  logic fp_chk_prev = 1'b0, fin_done = 1'b0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [1:0]   idx;
    logic [3:0]   sx;
    logic [34:0]  e;
    logic [72:0]  es;
    logic [127:0] rmask;
    idx = 2'd0;
    sx  = 4'd0;
    if (rst_chk) begin
      chk("rst_ctl", 128'({m_ack, m_err, m_hold, s_en, s_we, s_sel, dbg_state}), 128'(0));
      chk("rst_rdata", 128'(m_rdata), 128'(0));
      chk("rst_bus", 128'({s_addr, s_wdata}), 128'(0));
    end
    if (m_ack != 4'b0) begin
      chk("ack_onehot", 128'($onehot(m_ack)), 128'(1));
      for (int i = 0; i < NUM_M; i++) if (m_ack[i]) idx = 2'(i);
      if (exp_q.size() == 0) chk("ack_unexpected", 128'(m_ack), 128'(0));
      else begin
        e = exp_q.pop_front();
        chk("ack_resp", 128'({idx, m_err[idx], m_rdata[idx*DW +: DW]}), 128'(e));
      end
      rmask = 128'hFFFF_FFFF << (int'(idx) * DW);
      chk("rdata_lanes", m_rdata & ~rmask, 128'(0));
      chk("err_lanes", 128'(m_err & ~m_ack), 128'(0));
      if (lat_chk) chk("latency", 128'(cyc - req_cyc), 128'(2));
      if (gap_chk && gap_n > 0) chk("ack_gap", 128'(cyc - last_ack_cyc), 128'(3));
      if (gap_chk) gap_n++;
      last_ack_cyc = cyc;
      ack_cnt++;
    end
    if (!gap_chk) gap_n = 0;
    if (s_en != 4'b0) begin
      chk("s_en_onehot", 128'($onehot(s_en)), 128'(1));
      chk("s_we_lanes", 128'(s_we & ~s_en), 128'(0));
      for (int j = 0; j < NUM_S; j++) if (s_en[j]) sx = 4'(j);
      if (exp_s_q.size() == 0) chk("slave_unexpected", 128'(s_en), 128'(0));
      else begin
        es = exp_s_q.pop_front();
        chk("slave_bus", 128'({sx, s_we[sx[1:0]], s_addr, s_wdata, s_sel}), 128'(es));
      end
    end else begin
      chk("bus_idle", 128'({s_we, s_addr, s_wdata, s_sel}), 128'(0));
    end
    if (hold_chk) chk("hold", 128'(m_hold), 128'(exp_hold));
    if (fp_chk && fp_m_ack != 4'b0) begin
      chk("fp_grant", 128'(fp_m_ack), 128'(4'b0001));
      fp_n++;
    end
    if (fp_chk_prev && !fp_chk) chk("fp_count", 128'(fp_n), 128'(5));
    if (!fp_chk) fp_n = 0;
    fp_chk_prev = fp_chk;
    if (tmo_cnt != tmo_seen) begin
      chk("timeout", 128'(tmo_cnt), 128'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
    if (fin_chk && !fin_done) begin
      chk("exp_q_left", 128'(exp_q.size()), 128'(0));
      chk("exp_s_q_left", 128'(exp_s_q.size()), 128'(0));
      fin_done = 1'b1;
    end
  end

  // driver tasks: all return at posedge+1 inside an IDLE cycle
  task automatic set_m(int m, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    m_we[m]            = we;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
    m_sel[m*4 +: 4]    = s;
  endtask

  task automatic push_exp(int m);
    logic [31:0] a;
    logic [3:0]  sidx;
    a    = m_addr[m*AW +: AW];
    sidx = a[31:28];
    if (int'(sidx) >= NUM_S) exp_q.push_back({2'(m), 1'b1, 32'h0});
    else begin
      exp_s_q.push_back({sidx, m_we[m], a, m_wdata[m*DW +: DW], m_sel[m*4 +: 4]});
      exp_q.push_back({2'(m), 1'b0, m_we[m] ? 32'h0 : slv_data(int'(sidx), a)});
    end
  endtask

  task automatic wait_acks(int n);
    int start;
    int k;
    start = ack_cnt;
    k = 0;
    while (ack_cnt - start < n && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    if (ack_cnt - start < n) tmo_cnt++;
    @(posedge clk); #1;
    m_req = '0;
  endtask

  task automatic single(int m, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    set_m(m, we, a, d, s);
    push_exp(m);
    m_req[m] = 1'b1;
    req_cyc  = cyc;
    lat_chk  = 1'b1;
    wait_acks(1);
    lat_chk  = 1'b0;
  endtask

  logic [3:0] t6_req[7];
  logic [3:0] t6_hold[7];

  initial begin
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
    t6_req  = '{4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    t6_hold = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};

    // power-on reset
    rst_chk = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_chk = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // single read, byte write, decode error
    single(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    single(2, 1'b1, 32'h2000_0004, 32'h0000_AB00, 4'b0010);
    single(1, 1'b0, 32'h7000_0000, 32'h0, 4'hF);

    // reset mid-ACCESS: slave strobe still shows, no ack follows
    set_m(3, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    exp_s_q.push_back({4'd0, 1'b0, 32'h0000_0040, 32'h0, 4'hF});
    m_req[3] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    m_req = '0;
    @(posedge clk); #1;
    rst_chk = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_chk = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // all masters request continuously: grants 0,1,2,3,0 (master 0 first after reset)
    for (int m = 0; m < NUM_M; m++) set_m(m, 1'b0, {4'(m), 28'h000_0100 * (m + 1)}, 32'h0, 4'hF);
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    gap_chk = 1'b1;
    fp_chk  = 1'b1;
    m_req   = 4'hF;
    wait_acks(5);
    gap_chk = 1'b0;
    fp_chk  = 1'b0;

    // park the pointer on master 3, then m0 and m3 together for the hold check
    single(3, 1'b0, 32'h3000_0020, 32'h0, 4'hF);
    set_m(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF);
    set_m(3, 1'b0, 32'h2000_000C, 32'h0, 4'hF);
    push_exp(0);
    push_exp(3);
    hold_chk = 1'b1;
    for (int k = 0; k < 7; k++) begin
      m_req    = t6_req[k];
      exp_hold = t6_hold[k];
      @(posedge clk); #1;
    end
    hold_chk = 1'b0;

    // random single-master traffic, including out-of-range slave indices
    for (int n = 0; n < 24; n++) begin
      int m;
      int sidx;
      m    = $urandom_range(0, NUM_M - 1);
      sidx = $urandom_range(0, 5);
      single(m, 1'($urandom_range(0, 1)), {4'(sidx), 16'($urandom), 10'($urandom), 2'b00},
             $urandom, 4'($urandom_range(1, 15)));
    end

    repeat (2) @(posedge clk);
    #1 fin_chk = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
